uart_byte_transceiver: RTL and testbench

Full-duplex 8N1 UART byte engine that sits between the serial pins and the byte-exchange FIFO controller. It deserialises host bytes from the RX line into a parallel byte and serialises a parallel byte onto the TX line on request. A single ready flag marks when neither direction is busy. It supplies the ready flag, received byte and start handshake that the FIFO controller consumes.

---
 rtl/uart_byte_transceiver.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_byte_transceiver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_transceiver.sv
// Full-duplex 8N1 UART byte engine: serialises TX_DATA on START_FLAG, deserialises UART_RXD into RX_DATA.
// TX frame 10*CLK_PER_BIT cycles, RX start detect 3 cycles; START_FLAG while TX busy is dropped, RDY marks both paths idle.
module uart_byte_transceiver #(
    parameter int CLK_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       UART_RXD,
    output logic       UART_TXD,
    input  logic       START_FLAG,
    input  logic [7:0] TX_DATA,
    output logic [7:0] RX_DATA,
    output logic       RDY,
    output logic       RX_ERR
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        TXS_IDLE,
        TXS_START,
        TXS_DATA,
        TXS_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RXS_IDLE,
        RXS_START,
        RXS_DATA,
        RXS_STOP,
        RXS_WAIT_HIGH
    } rx_state_t;

    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          txd_q, txd_d;
    logic          tx_bit_end;

    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_err_q, rx_err_d;
    logic [2:0]    rx_sync_q, rx_sync_d;
    logic          rx_line;
    logic          rx_fall;
    logic          rx_bit_end;
    logic          rx_half_end;

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            tx_state_q <= TXS_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    assign tx_bit_end = (tx_cnt_q == BIT_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            TXS_IDLE: begin
                tx_cnt_d = '0;
                if (START_FLAG) begin
                    tx_state_d = TXS_START;
                    tx_shift_d = TX_DATA;
                    tx_idx_d   = 3'd0;
                end
            end
            TXS_START: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = 3'd0;
                    tx_state_d = TXS_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TXS_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 3'd7) begin
                        tx_state_d = TXS_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TXS_STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TXS_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TXS_IDLE;
        endcase
    end

    // Line level is registered from the upcoming state so UART_TXD is glitch-free.
    always_comb begin
        txd_d = 1'b1;
        case (tx_state_d)
            TXS_START: txd_d = 1'b0;
            TXS_DATA:  txd_d = tx_shift_q[tx_idx_d];
            default:   txd_d = 1'b1;
        endcase
    end

    assign UART_TXD = txd_q;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    always_comb begin
        rx_sync_d = {rx_sync_q[1:0], UART_RXD};
    end

    // [0],[1] are the synchroniser, [2] holds the previous synchronised level.
    assign rx_line     = rx_sync_q[1];
    assign rx_fall     = rx_sync_q[2] & ~rx_sync_q[1];
    assign rx_bit_end  = (rx_cnt_q == BIT_LAST);
    assign rx_half_end = (rx_cnt_q == HALF_LAST);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rx_sync_q  <= 3'b111;
            rx_state_q <= RXS_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_err_q   <= 1'b0;
        end else begin
            rx_sync_q  <= rx_sync_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_err_q   <= rx_err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            RXS_IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) begin
                    rx_state_d = RXS_START;
                end
            end
            RXS_START: begin
                if (rx_half_end) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = 3'd0;
                    rx_state_d = rx_line ? RXS_IDLE : RXS_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RXS_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_line, rx_shift_q[7:1]};
                    if (rx_idx_q == 3'd7) begin
                        rx_state_d = RXS_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RXS_STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_line ? RXS_IDLE : RXS_WAIT_HIGH;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RXS_WAIT_HIGH: begin
                rx_cnt_d = '0;
                if (rx_line) begin
                    rx_state_d = RXS_IDLE;
                end
            end
            default: begin
                rx_cnt_d   = '0;
                rx_state_d = RXS_IDLE;
            end
        endcase
    end

    // A false start leaves both RX_DATA and RX_ERR untouched.
    always_comb begin
        rx_data_d = rx_data_q;
        rx_err_d  = rx_err_q;
        if (rx_state_q == RXS_START && rx_half_end && !rx_line) begin
            rx_err_d = 1'b0;
        end
        if (rx_state_q == RXS_STOP && rx_bit_end) begin
            if (rx_line) begin
                rx_data_d = rx_shift_q;
            end else begin
                rx_err_d = 1'b1;
            end
        end
    end

    assign RX_DATA = rx_data_q;
    assign RX_ERR  = rx_err_q;
    assign RDY     = (rx_state_q == RXS_IDLE) && (tx_state_q == TXS_IDLE);

endmodule

// File: tb/tb_uart_byte_transceiver.sv
// Directed bench for uart_byte_transceiver at CLK_PER_BIT=8: table of TX/RX frames plus reset, false start and duplex sequences.
module tb_uart_byte_transceiver;

    localparam int N = 8;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       UART_RXD = 1'b1;
    logic       START_FLAG = 1'b0;
    logic [7:0] TX_DATA = 8'h00;
    logic       UART_TXD;
    logic [7:0] RX_DATA;
    logic       RDY;
    logic       RX_ERR;

    int checks = 0;
    int failures = 0;

    uart_byte_transceiver #(.CLK_PER_BIT(N)) dut (
        .CLK(CLK),
        .RSTN(RSTN),
        .UART_RXD(UART_RXD),
        .UART_TXD(UART_TXD),
        .START_FLAG(START_FLAG),
        .TX_DATA(TX_DATA),
        .RX_DATA(RX_DATA),
        .RDY(RDY),
        .RX_ERR(RX_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       is_tx;
        logic [7:0] dat;
        logic       stop;
        logic [9:0] exp_frame;
        logic [7:0] exp_rx;
        logic       exp_err;
        int         glitch;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Pulses START_FLAG for one cycle and checks every line bit across its full width.
    task automatic tx_frame(input logic [7:0] d, input logic [9:0] exp, input int glitch);
        logic bit_ok;
        logic rdy_low;
        START_FLAG = 1'b1;
        TX_DATA    = d;
        tick();
        START_FLAG = 1'b0;
        TX_DATA    = 8'h00;
        rdy_low    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bit_ok = 1'b1;
            for (int c = 0; c < N; c++) begin
                if (UART_TXD !== exp[k]) bit_ok = 1'b0;
                if (RDY !== 1'b0) rdy_low = 1'b0;
                START_FLAG = ((k * N + c) == glitch);
                TX_DATA    = ((k * N + c) == glitch) ? 8'hFF : 8'h00;
                tick();
            end
            check($sformatf("tx_bit%0d_held_%0d_cycles", k, N), {31'd0, bit_ok}, 32'd1);
        end
        START_FLAG = 1'b0;
        check("tx_rdy_low_whole_frame", {31'd0, rdy_low}, 32'd1);
        check("tx_line_idle_after_frame", {31'd0, UART_TXD}, 32'd1);
        check("tx_rdy_after_frame", {31'd0, RDY}, 32'd1);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop, input logic [7:0] exp_rx,
                            input logic exp_err, input logic duplex);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int t = 0; t < 10 * N; t++) begin
            UART_RXD = fr[t / N];
            tick();
            if (!duplex && t == 1) check("rx_rdy_before_detect", {31'd0, RDY}, 32'd1);
            if (!duplex && t == 2) check("rx_rdy_fall_3_cycles", {31'd0, RDY}, 32'd0);
            if (t == 77) check("rx_rdy_before_stop_sample", {31'd0, RDY}, 32'd0);
            if (t == 78) begin
                check("rx_data_at_stop", {24'd0, RX_DATA}, {24'd0, exp_rx});
                check("rx_err_at_stop", {31'd0, RX_ERR}, {31'd0, exp_err});
                check("rx_rdy_at_stop", {31'd0, RDY}, {31'd0, (!duplex && stop)});
            end
        end
        if (!stop) begin
            repeat (20) tick();
            check("rx_wait_high_rdy_low", {31'd0, RDY}, 32'd0);
            check("rx_wait_high_err_held", {31'd0, RX_ERR}, 32'd1);
            UART_RXD = 1'b1;
            tick();
            tick();
            check("rx_wait_high_sync_delay", {31'd0, RDY}, 32'd0);
            tick();
            check("rx_wait_high_release", {31'd0, RDY}, 32'd1);
            check("rx_data_kept_after_err", {24'd0, RX_DATA}, {24'd0, exp_rx});
        end
    endtask

    initial begin
        int low_cnt;

        // Frames written out LSB-first on the line: {stop, data, start}.
        vecs[0] = '{1'b1, 8'hA5, 1'b1, 10'h34A, 8'h00, 1'b0, 30};
        vecs[1] = '{1'b1, 8'h00, 1'b1, 10'h200, 8'h00, 1'b0, -1};
        vecs[2] = '{1'b1, 8'hFF, 1'b1, 10'h3FE, 8'h00, 1'b0, -1};
        vecs[3] = '{1'b0, 8'h3C, 1'b1, 10'h000, 8'h3C, 1'b0, -1};
        vecs[4] = '{1'b0, 8'h55, 1'b0, 10'h000, 8'h3C, 1'b1, -1};
        vecs[5] = '{1'b0, 8'h81, 1'b1, 10'h000, 8'h81, 1'b0, -1};

        repeat (3) tick();
        check("reset_txd", {31'd0, UART_TXD}, 32'd1);
        check("reset_rdy", {31'd0, RDY}, 32'd1);
        check("reset_rx_data", {24'd0, RX_DATA}, 32'd0);
        check("reset_rx_err", {31'd0, RX_ERR}, 32'd0);
        RSTN = 1'b1;
        repeat (2) tick();
        check("post_reset_txd", {31'd0, UART_TXD}, 32'd1);
        check("post_reset_rdy", {31'd0, RDY}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_tx) begin
                tx_frame(vecs[i].dat, vecs[i].exp_frame, vecs[i].glitch);
            end else begin
                rx_frame(vecs[i].dat, vecs[i].stop, vecs[i].exp_rx, vecs[i].exp_err, 1'b0);
            end
            repeat (3) tick();
        end

        // False start: two low cycles then high.
        UART_RXD = 1'b0;
        tick();
        tick();
        UART_RXD = 1'b1;
        low_cnt = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (RDY === 1'b0) low_cnt++;
        end
        check("false_start_rdy_low_cycles", low_cnt, 32'd4);
        check("false_start_rx_data", {24'd0, RX_DATA}, 32'h81);
        check("false_start_rx_err", {31'd0, RX_ERR}, 32'd0);
        check("false_start_txd_idle", {31'd0, UART_TXD}, 32'd1);

        // Full duplex: TX request lands during the 4th RX bit.
        fork
            rx_frame(8'hF0, 1'b1, 8'hF0, 1'b0, 1'b1);
            begin
                repeat (4 * N) tick();
                tx_frame(8'h0F, 10'h21E, -1);
            end
        join
        check("duplex_rx_data", {24'd0, RX_DATA}, 32'hF0);
        check("duplex_rx_err", {31'd0, RX_ERR}, 32'd0);

        // Reset in the middle of a TX frame.
        tick();
        START_FLAG = 1'b1;
        TX_DATA    = 8'h00;
        tick();
        START_FLAG = 1'b0;
        repeat (20) tick();
        check("mid_tx_line_low", {31'd0, UART_TXD}, 32'd0);
        check("mid_tx_rdy_low", {31'd0, RDY}, 32'd0);
        #1;
        RSTN = 1'b0;
        #1;
        check("async_reset_txd", {31'd0, UART_TXD}, 32'd1);
        check("async_reset_rdy", {31'd0, RDY}, 32'd1);
        check("async_reset_rx_data", {24'd0, RX_DATA}, 32'd0);
        tick();
        RSTN = 1'b1;
        repeat (3) tick();
        check("after_abort_txd", {31'd0, UART_TXD}, 32'd1);
        check("after_abort_rdy", {31'd0, RDY}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
